nand_if_ctrl: RTL

Serial NAND pin-interface controller inside `core`. Takes single-word read/write requests from the core's internal request port and drives the NAND pins (`nand_cs_o`, `nand_addr_o`, `nand_wdata_o`). It samples `nand_rdata_i` and returns one response per request. It sits directly upstream of `mux_top`, which routes its pin signals to the `P_NAND_*` pads. Each 8-bit word moves as four 2-bit beats, LSB first, with programmable setup, beat and hold timing.

---
 rtl/nand_if_ctrl_if.sv | 37 +++
 rtl/nand_if_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/nand_if_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nand_if_ctrl_if
// Brief    : Request/response port and NAND pin bundle for nand_if_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface nand_if_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_rdata;
    logic       resp_write;
    logic       busy_o;
    logic       nand_cs_o;
    logic [1:0] nand_addr_o;
    logic [1:0] nand_wdata_o;
    logic [1:0] nand_rdata_i;

    // Requester and NAND-side environment
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready, nand_rdata_i,
        input  req_ready, resp_valid, resp_rdata, resp_write, busy_o,
               nand_cs_o, nand_addr_o, nand_wdata_o
    );

    // Controller
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready, nand_rdata_i,
        output req_ready, resp_valid, resp_rdata, resp_write, busy_o,
               nand_cs_o, nand_addr_o, nand_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/nand_if_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nand_if_ctrl
// Brief    : Single-word NAND pin controller; 8-bit words as four 2-bit beats.
// Revision : 1.0 - initial release
// ============================================================================
module nand_if_ctrl #(
    parameter int SETUP_CYC = 2,
    parameter int BEAT_CYC  = 3,
    parameter int HOLD_CYC  = 1
) (
    input  logic          xtal_i,
    input  logic          reset_i,
    nand_if_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [3:0] c_SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] c_BEAT_LD  = 4'(BEAT_CYC - 1);
    localparam logic [3:0] c_HOLD_LD  = 4'(HOLD_CYC - 1);

    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 15 || BEAT_CYC < 1 || BEAT_CYC > 15 ||
            HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_param_check
            $error("nand_if_ctrl: SETUP_CYC/BEAT_CYC/HOLD_CYC must be in 1..15");
        end
    endgenerate

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_beat;
    logic       r_write;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata_acc;
    logic       r_req_ready;
    logic       r_resp_valid;
    logic [7:0] r_resp_rdata;
    logic       r_resp_write;
    logic       r_busy;
    logic       r_cs_n;
    logic [1:0] r_addr_pin;
    logic [1:0] r_wdata_pin;

    logic       w_req_hs;
    logic       w_cnt_done;
    logic [1:0] w_next_beat;
    logic [1:0] w_next_wbits;

    assign w_req_hs     = bus.req_valid & r_req_ready;
    assign w_cnt_done   = (r_cnt == 4'd0);
    assign w_next_beat  = r_beat + 2'd1;
    assign w_next_wbits = r_wdata[{w_next_beat, 1'b0} +: 2];

    // Pin outputs are loaded alongside the state change so they are valid
    // in the first cycle of the state they belong to.
    always_ff @(posedge xtal_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_beat       <= 2'd0;
            r_write      <= 1'b0;
            r_wdata      <= 8'h00;
            r_rdata_acc  <= 8'h00;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 8'h00;
            r_resp_write <= 1'b0;
            r_busy       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_addr_pin   <= 2'b00;
            r_wdata_pin  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_hs) begin
                        r_write     <= bus.req_write;
                        r_wdata     <= bus.req_wdata;
                        r_rdata_acc <= 8'h00;
                        r_state     <= S_SETUP;
                        r_cnt       <= c_SETUP_LD;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cs_n      <= 1'b0;
                        r_addr_pin  <= bus.req_addr;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_done) begin
                        r_state     <= S_XFER;
                        r_cnt       <= c_BEAT_LD;
                        r_beat      <= 2'd0;
                        r_wdata_pin <= r_write ? r_wdata[1:0] : 2'b00;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_XFER: begin
                    if (w_cnt_done) begin
                        // LSB-first beats shift in from the top
                        if (!r_write) begin
                            r_rdata_acc <= {bus.nand_rdata_i, r_rdata_acc[7:2]};
                        end
                        if (r_beat == 2'd3) begin
                            r_state <= S_HOLD;
                            r_cnt   <= c_HOLD_LD;
                        end else begin
                            r_beat      <= w_next_beat;
                            r_cnt       <= c_BEAT_LD;
                            r_wdata_pin <= r_write ? w_next_wbits : 2'b00;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_done) begin
                        r_state      <= S_RESP;
                        r_cs_n       <= 1'b1;
                        r_addr_pin   <= 2'b00;
                        r_wdata_pin  <= 2'b00;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_write ? 8'h00 : r_rdata_acc;
                        r_resp_write <= r_write;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_req_ready  <= 1'b0;
                    r_cs_n       <= 1'b1;
                    r_addr_pin   <= 2'b00;
                    r_wdata_pin  <= 2'b00;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_rdata   = r_resp_rdata;
    assign bus.resp_write   = r_resp_write;
    assign bus.busy_o       = r_busy;
    assign bus.nand_cs_o    = r_cs_n;
    assign bus.nand_addr_o  = r_addr_pin;
    assign bus.nand_wdata_o = r_wdata_pin;

endmodule
`default_nettype wire
